// File: rtl/mul_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier: FSM states,
// recoded digit flags and the iteration-counter width helper.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_digit_t;

  // Bits needed to count 0..n-1 (never less than one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// Combinational modified-Booth recoder: {Q[1],Q[0],Q[-1]} -> {neg, one, two}.
module booth_r4_recoder
  import mul_pkg::*;
(
  input  logic [2:0]   triple,
  output booth_digit_t digit
);

  always_comb begin
    digit.one = triple[1] ^ triple[0];
    digit.two = (triple == 3'b011) || (triple == 3'b100);
    // 3'b111 is a zero digit, so it must not be flagged negative
    digit.neg = triple[2] & ~(triple[1] & triple[0]);
  end

endmodule

// File: rtl/mul_booth_r4_seq.sv
// Sequential radix-4 Booth multiplier, two multiplier bits per clock.
// Optional unsigned mode is built when MUL_UNSIGNED_EN is defined.
module mul_booth_r4_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
`ifdef MUL_UNSIGNED_EN
  input  logic                 is_signed,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int AW = WIDTH + 2;
`ifdef MUL_UNSIGNED_EN
  localparam int QW   = WIDTH + 2;
  localparam int NMAX = WIDTH / 2 + 1;
`else
  localparam int QW   = WIDTH;
  localparam int NMAX = WIDTH / 2;
`endif
  localparam int CW = cnt_width(NMAX);
  localparam logic [CW-1:0] LAST_S = CW'(WIDTH / 2 - 1);

  state_t state_reg, state_next;
  logic [AW-1:0]      acc_reg, m_reg, m_load, addend, sum, acc_next;
  logic [QW-1:0]      q_reg, q_load, q_next;
  logic               qm1_reg;
  logic [CW-1:0]      cnt_reg, last_cnt;
  logic [2*WIDTH-1:0] product_reg, product_new;
  logic               load, step, last;
  booth_digit_t       digit;

`ifdef MUL_UNSIGNED_EN
  localparam logic [CW-1:0] LAST_U = CW'(WIDTH / 2);
  logic signed_reg;

  // Unsigned operands get two zero bits on top so the final triple sees Q's MSB as magnitude.
  assign m_load   = is_signed ? {{2{multiplicand[WIDTH-1]}}, multiplicand} : {2'b00, multiplicand};
  assign q_load   = is_signed ? {{2{multiplier[WIDTH-1]}}, multiplier} : {2'b00, multiplier};
  assign last_cnt = signed_reg ? LAST_S : LAST_U;
  assign product_new = signed_reg ? {acc_next[WIDTH-1:0], q_next[QW-1:2]}
                                  : {acc_next[WIDTH-3:0], q_next};
`else
  assign m_load      = {{2{multiplicand[WIDTH-1]}}, multiplicand};
  assign q_load      = multiplier;
  assign last_cnt    = LAST_S;
  assign product_new = {acc_next[WIDTH-1:0], q_next};
`endif

  booth_r4_recoder u_recoder (
    .triple ({q_reg[1:0], qm1_reg}),
    .digit  (digit)
  );

  always_comb begin
    addend   = digit.two ? {m_reg[AW-2:0], 1'b0} : (digit.one ? m_reg : '0);
    sum      = digit.neg ? (acc_reg - addend) : (acc_reg + addend);
    acc_next = {{2{sum[AW-1]}}, sum[AW-1:2]};
    q_next   = {sum[1:0], q_reg[QW-1:2]};
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    step       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (cnt_reg == last_cnt) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign last = step && (cnt_reg == last_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      acc_reg     <= '0;
      q_reg       <= '0;
      qm1_reg     <= 1'b0;
      m_reg       <= '0;
      cnt_reg     <= '0;
      product_reg <= '0;
`ifdef MUL_UNSIGNED_EN
      signed_reg  <= 1'b1;
`endif
    end else begin
      state_reg <= state_next;
      if (load) begin
        acc_reg    <= '0;
        q_reg      <= q_load;
        qm1_reg    <= 1'b0;
        m_reg      <= m_load;
        cnt_reg    <= '0;
`ifdef MUL_UNSIGNED_EN
        signed_reg <= is_signed;
`endif
      end else if (step) begin
        acc_reg <= acc_next;
        q_reg   <= q_next;
        qm1_reg <= q_reg[1];
        cnt_reg <= cnt_reg + 1'b1;
        if (last) product_reg <= product_new;
      end
    end
  end

  assign product = product_reg;

endmodule

// File: tb/tb_mul_booth_r4_seq.sv
// Scoreboard bench for mul_booth_r4_seq: the driver queues expected products,
// a negedge monitor checks product, done timing and busy length on every done.
module tb_mul_booth_r4_seq;

  localparam int W  = 16;
  localparam int NS = W / 2;
  localparam int NU = W / 2 + 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   m_in = '0;
  logic [W-1:0]   q_in = '0;
  logic           sgn_in = 1'b1;
  logic           busy, done;
  logic [2*W-1:0] product;

  mul_booth_r4_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (m_in),
    .multiplier   (q_in),
`ifdef MUL_UNSIGNED_EN
    .is_signed    (sgn_in),
`endif
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2*W-1:0] prod;
    int             done_cyc;
    int             n;
    string          name;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   busy_run = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: one line per completed transaction.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL spurious_done: done at cycle %0d with product 0x%h, expected no done", cyc, product);
        end else begin
          exp_t e;
          e = sb.pop_front();
          $display("txn %s: product=0x%h done_cycle=%0d busy_cycles=%0d", e.name, product, cyc, busy_run);
          check({e.name, "_product"}, 64'(product), 64'(e.prod));
          check({e.name, "_done_cycle"}, 64'(cyc), 64'(e.done_cyc));
          check({e.name, "_busy_cycles"}, 64'(busy_run), 64'(e.n));
        end
        busy_run = 0;
      end
    end
  end

  task automatic issue(input logic [W-1:0] m, input logic [W-1:0] q, input logic sgn,
                       input logic [2*W-1:0] exp, input int n, input string name);
    @(negedge clk);
    m_in   = m;
    q_in   = q;
    sgn_in = sgn;
    start  = 1'b1;
    sb.push_back('{exp, cyc + 1 + n, n, name});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy && !done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_total++;
      $display("FAIL %s_timeout: %0d results outstanding, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  logic [W-1:0]   vm [6] = '{16'h0002, 16'hFFFF, 16'h8000, 16'h8000, 16'h7FFF, 16'h1234};
  logic [W-1:0]   vq [6] = '{16'h0003, 16'hFFFF, 16'h8000, 16'h0001, 16'h8000, 16'h5678};
  logic [2*W-1:0] ve [6] = '{32'h0000_0006, 32'h0000_0001, 32'h4000_0000,
                             32'hFFFF_8000, 32'hC000_8000, 32'h0626_0060};

  initial begin
    int k;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_product", 64'(product), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      issue(vm[i], vq[i], 1'b1, ve[i], NS, $sformatf("signed%0d", i));
      wait_drain("signed");
    end

`ifdef MUL_UNSIGNED_EN
    issue(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, NU, "unsigned_ffff");
    wait_drain("unsigned");
    issue(16'h8000, 16'h0003, 1'b0, 32'h0001_8000, NU, "unsigned_8000x3");
    wait_drain("unsigned");
    issue(16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001, NS, "signed_ffff_mode");
    wait_drain("signed_mode");
`endif

    // start pulsed mid-RUN with other operands must be ignored
    issue(16'h0011, 16'h0003, 1'b1, 32'h0000_0033, NS, "ignore_start");
    repeat (2) @(negedge clk);
    m_in  = 16'h0100;
    q_in  = 16'h0100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain("ignore_start");
    repeat (NS + 4) @(negedge clk);

    // reset during iteration 4 aborts with no done
    @(negedge clk);
    m_in  = 16'h0055;
    q_in  = 16'h0002;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_product", 64'(product), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'h1234, 16'h0002, 1'b1, 32'h0000_2468, NS, "after_reset");
    wait_drain("after_reset");

    // back-to-back with start held high
    @(negedge clk);
    m_in   = 16'h0007;
    q_in   = 16'h0005;
    sgn_in = 1'b1;
    start  = 1'b1;
    k = cyc + 1;
    sb.push_back('{32'h0000_0023, k + NS, NS, "b2b_first"});
    @(negedge clk);
    m_in = 16'hFFFD;
    q_in = 16'h0004;
    sb.push_back('{32'hFFFF_FFF4, k + NS + 1 + NS, NS, "b2b_second"});
    repeat (NS) @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_drain("b2b");
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
